// File: rtl/gb_lcd_tx.sv
`default_nettype none
// gb_lcd_tx: replays fetcher pixels as the DMG LCD dot stream (456 dots x 154 lines, 160x144 visible).
// Optional build macro GB_LCD_TX_PATTERN_EN adds pattern_sel, a FIFO-independent test pattern.
module gb_lcd_tx #(
  parameter int FIFO_DEPTH    = 16,
  parameter int DOTS_PER_LINE = 456,
  parameter int LINES         = 154,
  parameter int VISIBLE_LINES = 144,
  parameter int WIDTH         = 160,
  parameter int OAM_DOTS      = 80
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ce,
  input  logic       lcd_en,
  input  logic       pix_valid,
  output logic       pix_ready,
  input  logic [1:0] pix_color,
`ifdef GB_LCD_TX_PATTERN_EN
  input  logic       pattern_sel,
`endif
  output logic       vs,
  output logic       hs,
  output logic       de,
  output logic [1:0] color,
  output logic [1:0] mode,
  output logic [7:0] ly,
  output logic [7:0] lx,
  output logic       underrun
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int DW = $clog2(DOTS_PER_LINE);

  localparam logic [DW-1:0] c_DOT_OAM_LAST = DW'(OAM_DOTS - 1);
  localparam logic [DW-1:0] c_DOT_DEAD     = DW'(DOTS_PER_LINE - 2);
  localparam logic [DW-1:0] c_DOT_LAST     = DW'(DOTS_PER_LINE - 1);
  localparam logic [7:0]    c_LY_VIS       = 8'(VISIBLE_LINES);
  localparam logic [7:0]    c_LY_LAST      = 8'(LINES - 1);
  localparam logic [7:0]    c_LX_W         = 8'(WIDTH);
  localparam logic [AW:0]   c_FULL         = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    M_HBLANK = 2'd0,
    M_VBLANK = 2'd1,
    M_OAM    = 2'd2,
    M_XFER   = 2'd3
  } mode_t;

  mode_t         r_mode;
  logic [DW-1:0] r_dot;
  logic [7:0]    r_ly;
  logic [7:0]    r_lx;
  logic [7:0]    r_accepted;
  logic          r_vs;
  logic          r_hs;
  logic          r_de;
  logic          r_underrun;
  logic [1:0]    r_color;

  logic [1:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_count;

  logic          w_visible;
  logic          w_empty;
  logic          w_full;
  logic          w_pattern;
  logic [1:0]    w_pix;
  logic          w_xfer;
  logic          w_emit;
  logic          w_pop;
  logic          w_push;
  logic          w_dead;
  logic          w_eol;
  logic          w_flush;
  logic [7:0]    w_lx_inc;
  logic [7:0]    w_ly_next;

`ifdef GB_LCD_TX_PATTERN_EN
  assign w_pattern = pattern_sel;
  assign w_pix     = pattern_sel ? (r_lx[4:3] ^ r_ly[4:3]) : r_mem[r_rptr];
`else
  assign w_pattern = 1'b0;
  assign w_pix     = r_mem[r_rptr];
`endif

  assign w_visible = (r_ly < c_LY_VIS);
  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == c_FULL);
  assign w_lx_inc  = r_lx + 8'd1;
  assign w_ly_next = r_ly + 8'd1;

  // Mode 3 is only ever entered with lx < WIDTH, so emission needs no lx compare.
  assign w_xfer  = ce & (r_mode == M_XFER);
  assign w_emit  = w_xfer & (w_pattern | ~w_empty);
  assign w_pop   = w_xfer & ~w_empty & ~w_pattern;
  assign w_dead  = w_xfer & ~w_pattern & (r_dot == c_DOT_DEAD) & ~(w_emit & (w_lx_inc == c_LX_W));
  assign w_eol   = ce & (r_dot == c_DOT_LAST);
  assign w_flush = w_eol | w_dead;

  assign pix_ready = rst & lcd_en & ~w_full & w_visible &
                     ((r_mode == M_OAM) | (r_mode == M_XFER)) & (r_accepted < c_LX_W);
  assign w_push    = pix_valid & pix_ready;

  assign vs       = r_vs;
  assign hs       = r_hs;
  assign de       = r_de;
  assign underrun = r_underrun;
  assign color    = r_color;
  assign mode     = r_mode;
  assign ly       = r_ly;
  assign lx       = r_lx;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= pix_color;
  end

  // A flush wins over a simultaneous push so no pixel crosses a line boundary.
  always_ff @(posedge clk) begin
    if (!rst || !lcd_en || w_flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst || !lcd_en || w_eol) r_accepted <= 8'd0;
    else if (w_push)              r_accepted <= r_accepted + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst || !lcd_en) begin
      r_dot      <= '0;
      r_ly       <= 8'd0;
      r_lx       <= 8'd0;
      r_mode     <= M_OAM;
      r_vs       <= 1'b0;
      r_hs       <= 1'b0;
      r_de       <= 1'b0;
      r_underrun <= 1'b0;
      r_color    <= 2'd0;
    end else begin
      r_vs       <= 1'b0;
      r_hs       <= 1'b0;
      r_de       <= 1'b0;
      r_underrun <= 1'b0;
      if (ce) begin
        if (r_dot == c_DOT_LAST) begin
          r_dot <= '0;
          r_lx  <= 8'd0;
          r_hs  <= w_visible;
          if (r_ly == c_LY_LAST) begin
            r_ly   <= 8'd0;
            r_mode <= M_OAM;
          end else begin
            r_ly   <= w_ly_next;
            r_mode <= (w_ly_next < c_LY_VIS) ? M_OAM : M_VBLANK;
          end
        end else begin
          r_dot <= r_dot + DW'(1);
          r_vs  <= (r_ly == c_LY_VIS) && (r_dot == '0);
          case (r_mode)
            M_OAM: begin
              if (r_dot == c_DOT_OAM_LAST) r_mode <= M_XFER;
            end
            M_XFER: begin
              if (w_emit) begin
                r_de    <= 1'b1;
                r_color <= w_pix;
                r_lx    <= w_lx_inc;
                if (w_lx_inc == c_LX_W) r_mode <= M_HBLANK;
              end
              if (w_dead) begin
                r_underrun <= 1'b1;
                r_mode     <= M_HBLANK;
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

endmodule
`default_nettype wire
